// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Free-running 640x480@60 Hz raster timing generator. It produces the pixel
//   coordinates, the active-video flag, and the horizontal/vertical sync pulses
//   for the downstream background and sprite renderers. It also produces a
//   one-cycle per-frame strobe for game logic.
//
// Ports:
//   vga_clk     in   1  pixel clock (25 MHz)
//   reset_n     in   1  asynchronous active-low reset
//   DrawX       out 10  current horizontal count, 0..H_TOTAL-1
//   DrawY       out 10  current vertical count, 0..V_TOTAL-1
//   hs          out  1  horizontal sync, active low
//   vs          out  1  vertical sync, active low
//   blank       out  1  1 = active video, 0 = blanking
//   frame_tick  out  1  one-cycle pulse on the last clock of each frame
//
// Build option:
//   VGA_SYNC_DELAY_EN - when defined, hs/vs/blank are delayed by SYNC_DELAY
//   extra register stages so that they line up with the renderers'
//   ROM + palette + output-register latency. DrawX, DrawY and frame_tick are
//   never delayed. When the macro is undefined there are no extra stages.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_tick
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // The counters are 10 bits wide, so the raster must fit in 1024x1024.
   generate
      if (H_TOTAL > 1024) begin : g_bad_h_total
         $error("vga_timing_gen: H_TOTAL exceeds 1024");
      end
      if (V_TOTAL > 1024) begin : g_bad_v_total
         $error("vga_timing_gen: V_TOTAL exceeds 1024");
      end
      if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_sync_delay
         $error("vga_timing_gen: SYNC_DELAY must be in 1..4");
      end
   endgenerate

   // Counter state (presented directly as DrawX/DrawY)
   logic [9:0] r_hc;
   logic [9:0] r_vc;

   // Registered decodes
   logic       r_hs;
   logic       r_vs;
   logic       r_blank;
   logic       r_frame_tick;

   // Next-state counter values and their decodes
   logic       w_h_wrap;
   logic [9:0] w_hc_next;
   logic [9:0] w_vc_next;
   logic       w_hs_next;
   logic       w_vs_next;
   logic       w_blank_next;
   logic       w_frame_tick_next;

   always_comb begin
      w_h_wrap  = (r_hc == H_LAST);
      w_hc_next = w_h_wrap ? 10'd0 : r_hc + 10'd1;
      w_vc_next = r_vc;
      if (w_h_wrap) begin
         w_vc_next = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
      end

      // Decoding the *next* counter values lets the registered flags describe
      // the same coordinate that DrawX/DrawY present on the same cycle.
      w_hs_next         = !((int'(w_hc_next) >= HS_START) && (int'(w_hc_next) < HS_END));
      w_vs_next         = !((int'(w_vc_next) >= VS_START) && (int'(w_vc_next) < VS_END));
      w_blank_next      = (int'(w_hc_next) < H_VISIBLE) && (int'(w_vc_next) < V_VISIBLE);
      w_frame_tick_next = (w_hc_next == H_LAST) && (w_vc_next == V_LAST);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hc         <= 10'd0;
         r_vc         <= 10'd0;
         r_hs         <= 1'b1;
         r_vs         <= 1'b1;
         // Held low in reset even though (0,0) is a visible coordinate.
         r_blank      <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_hc         <= w_hc_next;
         r_vc         <= w_vc_next;
         r_hs         <= w_hs_next;
         r_vs         <= w_vs_next;
         r_blank      <= w_blank_next;
         r_frame_tick <= w_frame_tick_next;
      end
   end

   assign DrawX      = r_hc;
   assign DrawY      = r_vc;
   assign frame_tick = r_frame_tick;

`ifdef VGA_SYNC_DELAY_EN
   // Each stage holds one delayed copy of hs/vs/blank. Stage 0 is fed from
   // the decode registers, and the last stage drives the outputs.
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_DELAY; gi++) begin : g_dly
         logic r_hs_s;
         logic r_vs_s;
         logic r_blank_s;
         logic w_hs_in;
         logic w_vs_in;
         logic w_blank_in;

         if (gi == 0) begin : g_first
            assign w_hs_in    = r_hs;
            assign w_vs_in    = r_vs;
            assign w_blank_in = r_blank;
         end else begin : g_rest
            assign w_hs_in    = g_dly[gi-1].r_hs_s;
            assign w_vs_in    = g_dly[gi-1].r_vs_s;
            assign w_blank_in = g_dly[gi-1].r_blank_s;
         end

         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               r_hs_s    <= 1'b1;
               r_vs_s    <= 1'b1;
               r_blank_s <= 1'b0;
            end else begin
               r_hs_s    <= w_hs_in;
               r_vs_s    <= w_vs_in;
               r_blank_s <= w_blank_in;
            end
         end
      end
   endgenerate

   assign hs    = g_dly[SYNC_DELAY-1].r_hs_s;
   assign vs    = g_dly[SYNC_DELAY-1].r_vs_s;
   assign blank = g_dly[SYNC_DELAY-1].r_blank_s;
`else
   assign hs    = r_hs;
   assign vs    = r_vs;
   assign blank = r_blank;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen in the default build (no sync delay stages).
// u_dut uses the full 640x480 timing and is used for reset behaviour and for
// line-level edges. u_small uses a shrunken raster (24 x 13) so that whole
// frames, the double wrap and frame_tick spacing can be exercised in a few
// hundred cycles.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   // Small raster geometry
   localparam int SH_VIS = 16, SH_FP = 2, SH_SY = 3, SH_BP = 3;
   localparam int SV_VIS = 8,  SV_FP = 1, SV_SY = 2, SV_BP = 2;
   localparam int SH_TOT = SH_VIS + SH_FP + SH_SY + SH_BP;   // 24
   localparam int SV_TOT = SV_VIS + SV_FP + SV_SY + SV_BP;   // 13
   localparam int S_FRAME = SH_TOT * SV_TOT;                 // 312

   logic       vga_clk;
   logic       reset_n;

   logic [9:0] d_x, d_y;
   logic       d_hs, d_vs, d_blank, d_ft;
   logic [9:0] s_x, s_y;
   logic       s_hs, s_vs, s_blank, s_ft;

   int total;
   int bad;

   vga_timing_gen u_dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .DrawX      (d_x),
      .DrawY      (d_y),
      .hs         (d_hs),
      .vs         (d_vs),
      .blank      (d_blank),
      .frame_tick (d_ft)
   );

   vga_timing_gen #(
      .H_VISIBLE (SH_VIS), .H_FRONT (SH_FP), .H_SYNC (SH_SY), .H_BACK (SH_BP),
      .V_VISIBLE (SV_VIS), .V_FRONT (SV_FP), .V_SYNC (SV_SY), .V_BACK (SV_BP),
      .SYNC_DELAY (2)
   ) u_small (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .DrawX      (s_x),
      .DrawY      (s_y),
      .hs         (s_hs),
      .vs         (s_vs),
      .blank      (s_blank),
      .frame_tick (s_ft)
   );

   initial vga_clk = 1'b0;
   always #20 vga_clk = ~vga_clk;

   typedef struct {
      int   adv;
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic blank;
      logic ft;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge vga_clk);
      #1;
   endtask

   task automatic chk_dut(input string tag, input int x, input int y,
                          input logic hs, input logic vs, input logic bl, input logic ft);
      chk({tag, ".DrawX"}, int'(d_x), x);
      chk({tag, ".DrawY"}, int'(d_y), y);
      chk({tag, ".hs"}, int'(d_hs), int'(hs));
      chk({tag, ".vs"}, int'(d_vs), int'(vs));
      chk({tag, ".blank"}, int'(d_blank), int'(bl));
      chk({tag, ".frame_tick"}, int'(d_ft), int'(ft));
   endtask

   initial begin
      int mx, my, n, hs_low, vs_low, s_hs_low;
      int ticks[$];
      logic e_hs, e_vs, e_bl, e_ft;

      total = 0;
      bad   = 0;

      //             adv   x    y  hs    vs    blank ft
      vecs[0] = '{   1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{ 638,  639,   0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{   1,  640,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{  15,  655,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{   1,  656,   0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{  95,  751,   0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{   1,  752,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{  47,  799,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{   1,    0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{   1,    1,   1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset held for 5 clocks
      reset_n = 1'b0;
      step(5);
      chk_dut("reset", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("reset.small.blank", int'(s_blank), 0);
      $display("reset held 5 clocks: DrawX=%0d DrawY=%0d hs=%0b vs=%0b blank=%0b",
               d_x, d_y, d_hs, d_vs, d_blank);

      // Release away from the active edge; then walk one line from the table
      @(negedge vga_clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].adv);
         chk_dut($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                 vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].ft);
         $display("vec%0d: +%0d clk -> DrawX=%0d DrawY=%0d hs=%0b blank=%0b",
                  i, vecs[i].adv, d_x, d_y, d_hs, d_blank);
      end

      // Count hs-low clocks over one complete line (starting at DrawX=1)
      hs_low = 0;
      for (int i = 0; i < 800; i++) begin
         step(1);
         if (!d_hs) hs_low++;
      end
      chk("line.hs_low_clocks", hs_low, 96);
      chk("line.end.DrawX", int'(d_x), 1);
      chk("line.end.DrawY", int'(d_y), 2);
      $display("line scan: hs low for %0d clocks, now at (%0d,%0d)", hs_low, d_x, d_y);

      // Restart both instances and scan the small raster clock by clock
      #5 reset_n = 1'b0;
      @(negedge vga_clk);
      reset_n = 1'b1;
      mx = 0; my = 0; vs_low = 0; s_hs_low = 0;
      for (n = 1; n <= 1100; n++) begin
         step(1);
         if (mx == SH_TOT - 1) begin
            mx = 0;
            my = (my == SV_TOT - 1) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
         e_hs = !((mx >= SH_VIS + SH_FP) && (mx < SH_VIS + SH_FP + SH_SY));
         e_vs = !((my >= SV_VIS + SV_FP) && (my < SV_VIS + SV_FP + SV_SY));
         e_bl = (mx < SH_VIS) && (my < SV_VIS);
         e_ft = (mx == SH_TOT - 1) && (my == SV_TOT - 1);
         chk($sformatf("small@%0d.DrawX", n), int'(s_x), mx);
         chk($sformatf("small@%0d.DrawY", n), int'(s_y), my);
         chk($sformatf("small@%0d.hs", n), int'(s_hs), int'(e_hs));
         chk($sformatf("small@%0d.vs", n), int'(s_vs), int'(e_vs));
         chk($sformatf("small@%0d.blank", n), int'(s_blank), int'(e_bl));
         chk($sformatf("small@%0d.frame_tick", n), int'(s_ft), int'(e_ft));
         if (n <= S_FRAME && !s_vs) vs_low++;
         if (n <= SH_TOT && !s_hs) s_hs_low++;
         if (s_ft) begin
            ticks.push_back(n);
            $display("frame_tick at clock %0d: (%0d,%0d)", n, s_x, s_y);
         end
      end
      chk("small.vs_low_clocks", vs_low, SV_SY * SH_TOT);
      chk("small.hs_low_clocks", s_hs_low, SH_SY);
      chk("small.tick_count", ticks.size(), 3);
      if (ticks.size() >= 3) begin
         chk("small.tick_gap1", ticks[1] - ticks[0], S_FRAME);
         chk("small.tick_gap2", ticks[2] - ticks[1], S_FRAME);
      end
      // 1100 clocks into the full raster: (300,1)
      chk("mid.DrawX", int'(d_x), 300);
      chk("mid.DrawY", int'(d_y), 1);
      chk("mid.small.hs", int'(s_hs), 0);
      $display("mid-frame: full=(%0d,%0d) small=(%0d,%0d) hs=%0b", d_x, d_y, s_x, s_y, s_hs);

      // Asynchronous reset mid-frame: outputs change with no clock edge
      #5 reset_n = 1'b0;
      #1;
      chk_dut("async", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("async.small.DrawX", int'(s_x), 0);
      chk("async.small.DrawY", int'(s_y), 0);
      chk("async.small.hs", int'(s_hs), 1);
      $display("async reset: DrawX=%0d DrawY=%0d hs=%0b blank=%0b", d_x, d_y, d_hs, d_blank);

      step(1);
      chk("async.hold.DrawX", int'(d_x), 0);
      @(negedge vga_clk);
      reset_n = 1'b1;
      step(1);
      chk_dut("restart", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("restart.small.DrawX", int'(s_x), 1);
      chk("restart.small.blank", int'(s_blank), 1);
      $display("restart: DrawX=%0d DrawY=%0d blank=%0b", d_x, d_y, d_blank);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
